register_write_arbiter: RTL and testbench

Shares the register file's single write port between NUM_SOURCES writeback requesters, for example the ALU, the load unit and the CSR/mul-div unit. Each requester uses a valid/ready handshake. A round-robin grant selects one requester per cycle, and the winning write is registered before it drives the register file's write address, data and enable inputs. The block sits between the execute/memory writeback paths and register_file.

---
 rtl/register_write_arbiter.sv | 87 ++++++++
 tb/tb_register_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port
// between NUM_SOURCES writeback requesters, with a one-cycle registered write.
module register_write_arbiter #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SOURCES    = 3
) (
  input  logic                                  i_Clock,
  input  logic                                  i_Reset_N,
  input  logic [NUM_SOURCES-1:0]                i_Src_Valid,
  output logic [NUM_SOURCES-1:0]                o_Src_Ready,
  input  logic [NUM_SOURCES*REG_ADDR_WIDTH-1:0] i_Src_Addr,
  input  logic [NUM_SOURCES*XLEN-1:0]           i_Src_Data,
  output logic                                  o_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0]             o_Write_Addr,
  output logic [XLEN-1:0]                       o_Write_Data,
  output logic [$clog2(NUM_SOURCES)-1:0]        o_Grant_Id
);

  localparam int ID_W = $clog2(NUM_SOURCES);

  // Handshake: source k transfers on a rising edge where i_Src_Valid[k] and
  // o_Src_Ready[k] are both 1. A requester holds valid/addr/data stable until
  // ready; ready is never a function of the source's own addr or data.

  logic [ID_W-1:0]           rr_ptr;
  logic [ID_W-1:0]           sel;
  logic [ID_W:0]             idx;
  logic                      found;
  logic [NUM_SOURCES-1:0]    src_ready;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [XLEN-1:0]           sel_data;
  logic                      transfer;

  // Scan from the pointer upward with wrap; idx is one bit wider to hold ptr+i.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_SOURCES)) idx = idx - (ID_W+1)'(NUM_SOURCES);
      if (!found && i_Src_Valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[ID_W-1:0];
      end
    end
  end

  // Ready is forced low while reset is asserted, regardless of requests.
  always_comb begin
    src_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (i_Reset_N && found && (sel == ID_W'(k))) begin
        src_ready[k] = 1'b1;
        sel_addr     = i_Src_Addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data     = i_Src_Data[k*XLEN +: XLEN];
      end
    end
  end

  assign transfer    = |src_ready;
  assign o_Src_Ready = src_ready;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      rr_ptr         <= '0;
      o_Write_Enable <= 1'b0;
      o_Write_Addr   <= '0;
      o_Write_Data   <= '0;
      o_Grant_Id     <= '0;
    end else begin
      o_Write_Enable <= 1'b0;
      if (transfer) begin
        // x0 requests are consumed but never reach the register file.
        o_Write_Enable <= (sel_addr != '0);
        o_Write_Addr   <= sel_addr;
        o_Write_Data   <= sel_data;
        o_Grant_Id     <= sel;
        rr_ptr         <= (sel == ID_W'(NUM_SOURCES-1)) ? '0 : sel + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Randomized and directed bench for register_write_arbiter, checked every
// cycle against a queue/arithmetic model of the round-robin write port.
module tb_register_write_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int N    = 3;
  localparam int ID_W = $clog2(N);
  localparam int W    = AW + XLEN;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      valid;
  logic [AW-1:0]     s_addr [N];
  logic [XLEN-1:0]   s_data [N];
  logic [N*AW-1:0]   addr_bus;
  logic [N*XLEN-1:0] data_bus;

  logic [N-1:0]      ready;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic [ID_W-1:0]   gid;

  always_comb begin
    addr_bus = '0;
    data_bus = '0;
    for (int k = 0; k < N; k++) begin
      addr_bus[k*AW +: AW]     = s_addr[k];
      data_bus[k*XLEN +: XLEN] = s_data[k];
    end
  end

  register_write_arbiter #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_SOURCES(N)) dut (
    .i_Clock(clk),
    .i_Reset_N(rst_n),
    .i_Src_Valid(valid),
    .o_Src_Ready(ready),
    .i_Src_Addr(addr_bus),
    .i_Src_Data(data_bus),
    .o_Write_Enable(we),
    .o_Write_Addr(waddr),
    .o_Write_Data(wdata),
    .o_Grant_Id(gid)
  );

  // ---------------- model and scoreboard ----------------
  int              total = 0;
  int              bad   = 0;
  int              m_ptr;
  bit              m_in_reset;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  int              m_gid;
  int              last_g;
  int              wait_cnt [N];
  logic [W-1:0]    exp_q [$];
  logic [XLEN-1:0] dut_rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (m_in_reset) return -1;
    for (int i = 0; i < N; i++) begin
      if (valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_in_reset = 1'b1;
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_gid = 0; last_g = -1;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    exp_q.delete();
  endtask

  // Called at each rising edge with the inputs the DUT sampled.
  task automatic model_step();
    int g;
    last_g = -1;
    if (!rst_n) return;
    g = exp_grant();
    for (int k = 0; k < N; k++) begin
      if (valid[k] && k != g) wait_cnt[k]++;
    end
    if (g >= 0) begin
      chk("fairness_wait", 64'(wait_cnt[g] <= N - 1), 64'd1);
      wait_cnt[g] = 0;
      m_we   = (s_addr[g] != 0);
      m_addr = s_addr[g];
      m_data = s_data[g];
      m_gid  = g;
      m_ptr  = (g + 1) % N;
      last_g = g;
      if (s_addr[g] != 0) exp_q.push_back({s_addr[g], s_data[g]});
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Compare process: outputs against the model, sampled at the falling edge.
  task automatic check();
    int g;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] e;
    g = exp_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 64'(ready), 64'(exp_rdy));
    chk("write_enable", 64'(we), 64'(m_we));
    chk("write_addr", 64'(waddr), 64'(m_addr));
    chk("write_data", 64'(wdata), 64'(m_data));
    chk("grant_id", 64'(gid), 64'(m_gid));
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(waddr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_order", 64'({waddr, wdata}), 64'(e));
      end
      if (waddr != 0) dut_rf[waddr] = wdata;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    model_step();
    #1;
    if (last_g >= 0) valid[last_g] = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    valid[k]  = 1'b1;
    s_addr[k] = a;
    s_data[k] = d;
  endtask

  task automatic do_reset();
    valid = '0;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    m_in_reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    valid = '0;
    for (int k = 0; k < N; k++) begin
      s_addr[k] = '0;
      s_data[k] = '0;
    end
    for (int r = 0; r < 32; r++) dut_rf[r] = '0;
    rst_n = 1'b0;
    model_reset();

    // Reset with all sources requesting: nothing granted, nothing written.
    for (int k = 0; k < N; k++) set_src(k, AW'(k + 1), XLEN'(32'h100 + k));
    #2;
    chk("reset_ready", 64'(ready), 64'b000);
    chk("reset_we", 64'(we), 64'd0);
    tick();
    rst_n = 1'b1;
    m_in_reset = 1'b0;
    #1;
    chk("post_reset_ready", 64'(ready), 64'b001);
    tick();
    chk("post_reset_gid", 64'(gid), 64'd0);

    // Single source.
    do_reset();
    set_src(1, 5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 64'(ready), 64'b010);
    tick();
    chk("single_we", 64'(we), 64'd1);
    chk("single_addr", 64'(waddr), 64'd5);
    chk("single_data", 64'(wdata), 64'hDEADBEEF);
    chk("single_gid", 64'(gid), 64'd1);
    tick();
    chk("single_rf_x5", 64'(dut_rf[5]), 64'hDEADBEEF);

    // Round-robin with every source continuously requesting.
    do_reset();
    for (int k = 0; k < N; k++) set_src(k, AW'(k + 1), XLEN'(32'hA0 + k));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_gid", 64'(gid), 64'(seq[i]));
      chk("rr_we", 64'(we), 64'd1);
      for (int k = 0; k < N; k++) valid[k] = 1'b1;
    end

    // x0 request is consumed but never written; pointer wraps to 0.
    do_reset();
    set_src(2, 0, 32'h1234);
    #1;
    chk("x0_ready", 64'(ready), 64'b100);
    tick();
    chk("x0_we", 64'(we), 64'd0);
    set_src(0, 1, 32'h1);
    set_src(1, 2, 32'h2);
    #1;
    chk("x0_ptr_wrap", 64'(ready), 64'b001);
    tick();
    tick();

    // Same-address requests commit in grant order.
    do_reset();
    set_src(0, 7, 32'h11);
    set_src(1, 7, 32'h22);
    tick();
    chk("same_addr_first", 64'(wdata), 64'h11);
    tick();
    chk("same_addr_second", 64'(wdata), 64'h22);
    tick();
    chk("same_addr_rf_x7", 64'(dut_rf[7]), 64'h22);

    // Asynchronous reset while a write is pending.
    do_reset();
    set_src(1, 9, 32'hCAFE);
    tick();
    chk("async_pre_we", 64'(we), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_we_cleared", 64'(we), 64'd0);
    chk("async_ready", 64'(ready), 64'b000);
    tick();
    chk("async_rf_x9", 64'(dut_rf[9]), 64'd0);
    rst_n = 1'b1;
    m_in_reset = 1'b0;

    // Randomized traffic; small address range forces collisions and x0.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!valid[k] && $urandom_range(0, 99) < 60)
          set_src(k, AW'($urandom_range(0, 7)), XLEN'($urandom));
      end
      tick();
    end
    valid = '0;
    tick();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
